// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors judge and match controller.
package rps_pkg;

  localparam logic [1:0] SCORE_TIE = 2'b00;
  localparam logic [1:0] SCORE_A   = 2'b01;
  localparam logic [1:0] SCORE_B   = 2'b10;
  localparam logic [1:0] SCORE_BAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

endpackage

// File: rtl/rps_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module rps_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match controller: tallies judged rounds and declares a match winner at WINS_TO_MATCH.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int WINS_TO_MATCH = 3,
  parameter int CNT_W         = 3,
  parameter int TIE_W         = 4,
  parameter int RND_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_match,
  input  logic             round_valid,
  input  logic [1:0]       score,
  output logic             round_ready,
  output logic [CNT_W-1:0] wins_a,
  output logic [CNT_W-1:0] wins_b,
  output logic [TIE_W-1:0] ties,
  output logic [RND_W-1:0] rounds,
  output logic             match_over,
  output logic [1:0]       winner,
  output logic             bad_round
);

  localparam logic [CNT_W:0] WIN_LAST = (CNT_W+1)'(WINS_TO_MATCH - 1);

  state_t     state, state_nxt;
  logic [1:0] winner_nxt;
  logic       bad_nxt;
  logic       take, inc_a, inc_b, inc_t, inc_r, final_a, final_b;

  // A strobe counts only in PLAY and only when no restart arrives alongside it.
  assign take    = (state == ST_PLAY) && round_valid && !new_match;
  assign inc_a   = take && (score == SCORE_A);
  assign inc_b   = take && (score == SCORE_B);
  assign inc_t   = take && (score == SCORE_TIE);
  assign inc_r   = take && (score != SCORE_BAD);
  assign final_a = inc_a && ({1'b0, wins_a} == WIN_LAST);
  assign final_b = inc_b && ({1'b0, wins_b} == WIN_LAST);

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    bad_nxt    = 1'b0;
    if (new_match) begin
      state_nxt  = ST_PLAY;
      winner_nxt = WIN_NONE;
    end else if (state == ST_PLAY) begin
      bad_nxt = round_valid && (score == SCORE_BAD);
      if (final_a) begin
        state_nxt  = ST_DONE;
        winner_nxt = WIN_A;
      end else if (final_b) begin
        state_nxt  = ST_DONE;
        winner_nxt = WIN_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      winner    <= WIN_NONE;
      bad_round <= 1'b0;
    end else begin
      state     <= state_nxt;
      winner    <= winner_nxt;
      bad_round <= bad_nxt;
    end
  end

  assign round_ready = (state == ST_PLAY);
  assign match_over  = (state == ST_DONE);

  rps_sat_counter #(.W(CNT_W)) u_wins_a (
    .clk(clk), .reset(reset), .clr(new_match), .inc(inc_a), .q(wins_a));
  rps_sat_counter #(.W(CNT_W)) u_wins_b (
    .clk(clk), .reset(reset), .clr(new_match), .inc(inc_b), .q(wins_b));
  rps_sat_counter #(.W(TIE_W)) u_ties (
    .clk(clk), .reset(reset), .clr(new_match), .inc(inc_t), .q(ties));
  rps_sat_counter #(.W(RND_W)) u_rounds (
    .clk(clk), .reset(reset), .clr(new_match), .inc(inc_r), .q(rounds));

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Bench for rps_match_ctrl: default instance plus a narrow-counter instance, checked against a rule model.
module tb_rps_match_ctrl;

  logic       clk = 1'b0;
  logic       reset, new_match, round_valid;
  logic [1:0] score;

  logic       r0, o0, b0, r1, o1, b1;
  logic [2:0] wa0, wb0, wa1, wb1;
  logic [3:0] t0;
  logic [4:0] n0;
  logic [1:0] t1, w0, w1;
  logic [2:0] n1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rps_match_ctrl dut0 (
    .clk(clk), .reset(reset), .new_match(new_match), .round_valid(round_valid),
    .score(score), .round_ready(r0), .wins_a(wa0), .wins_b(wb0), .ties(t0),
    .rounds(n0), .match_over(o0), .winner(w0), .bad_round(b0));

  rps_match_ctrl #(.WINS_TO_MATCH(7), .CNT_W(3), .TIE_W(2), .RND_W(3)) dut1 (
    .clk(clk), .reset(reset), .new_match(new_match), .round_valid(round_valid),
    .score(score), .round_ready(r1), .wins_a(wa1), .wins_b(wb1), .ties(t1),
    .rounds(n1), .match_over(o1), .winner(w1), .bad_round(b1));

  // Reference model: 0 = idle, 1 = playing, 2 = decided
  int ms[2], mwa[2], mwb[2], mti[2], mrn[2], mwin[2], mbad[2];
  int pw[2]   = '{3, 7};
  int tmax[2] = '{15, 3};
  int rmax[2] = '{31, 7};

  task automatic model_step(input bit rst, input bit nm, input bit rv, input logic [1:0] sc);
    for (int k = 0; k < 2; k++) begin
      mbad[k] = 0;
      if (rst || nm) begin
        ms[k] = rst ? 0 : 1;
        mwa[k] = 0; mwb[k] = 0; mti[k] = 0; mrn[k] = 0; mwin[k] = 0;
      end else if (ms[k] == 1 && rv) begin
        if (sc == 2'b11) mbad[k] = 1;
        else begin
          if (mrn[k] < rmax[k]) mrn[k]++;
          if (sc == 2'b00 && mti[k] < tmax[k]) mti[k]++;
          if (sc == 2'b01) begin
            mwa[k]++;
            if (mwa[k] == pw[k]) begin ms[k] = 2; mwin[k] = 1; end
          end
          if (sc == 2'b10) begin
            mwb[k]++;
            if (mwb[k] == pw[k]) begin ms[k] = 2; mwin[k] = 2; end
          end
        end
      end
    end
  endtask

  function automatic logic [19:0] expv(input int k);
    return {(ms[k] == 1), 3'(mwa[k]), 3'(mwb[k]), 4'(mti[k]), 5'(mrn[k]),
            (ms[k] == 2), 2'(mwin[k]), 1'(mbad[k])};
  endfunction

  function automatic logic [19:0] obs(input int k);
    if (k == 0) return {r0, wa0, wb0, t0, n0, o0, w0, b0};
    return {r1, wa1, wb1, 2'b00, t1, 2'b00, n1, o1, w1, b1};
  endfunction

  task automatic cyc(input bit rst, input bit nm, input bit rv, input logic [1:0] sc);
    reset = rst; new_match = nm; round_valid = rv; score = sc;
    @(posedge clk);
    #1;
    model_step(rst, nm, rv, sc);
    reset = 1'b0; new_match = 1'b0; round_valid = 1'b0; score = 2'b00;
  endtask

  task automatic test_reset;
    cyc(1, 0, 1, 2'b01);
    cyc(1, 1, 0, 2'b00);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 20'd0) begin
        bad++; $display("FAIL reset dut%0d: got %h want 00000", k, obs(k));
      end
    end
    cyc(0, 0, 1, 2'b01);
    total++;
    if (obs(0) !== 20'd0) begin
      bad++; $display("FAIL idle_ignore: got %h want 00000", obs(0));
    end
  endtask

  task automatic test_new_match;
    cyc(0, 1, 0, 2'b00);
    total++;
    if (obs(0) !== 20'h80000) begin
      bad++; $display("FAIL new_match: got %h want 80000", obs(0));
    end
  endtask

  task automatic test_match;
    logic [1:0] seq[5] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01};
    cyc(0, 1, 0, 2'b00);
    foreach (seq[i]) begin
      cyc(0, 0, 1, seq[i]);
      total++;
      if (obs(0) !== expv(0)) begin
        bad++; $display("FAIL match_step%0d: got %h want %h", i, obs(0), expv(0));
      end
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if ({wa0, wb0, t0, n0, o0, w0, r0} !== {3'd3, 3'd1, 4'd1, 5'd5, 1'b1, 2'b01, 1'b0}) begin
        bad++;
        $display("FAIL match_final%0d: got wa=%0d wb=%0d t=%0d n=%0d over=%b win=%b rdy=%b want 3 1 1 5 1 01 0",
                 j, wa0, wb0, t0, n0, o0, w0, r0);
      end
      cyc(0, 0, 1, (j == 0) ? 2'b10 : 2'b11);
      total++;
      if (b0 !== 1'b0) begin
        bad++; $display("FAIL done_no_bad%0d: got %b want 0", j, b0);
      end
    end
  endtask

  task automatic test_bad;
    cyc(0, 1, 0, 2'b00);
    cyc(0, 0, 1, 2'b01);
    cyc(0, 0, 1, 2'b11);
    total++;
    if ({b0, wa0, n0} !== {1'b1, 3'd1, 5'd1}) begin
      bad++; $display("FAIL bad_pulse: got b=%b wa=%0d n=%0d want 1 1 1", b0, wa0, n0);
    end
    cyc(0, 0, 0, 2'b00);
    total++;
    if ({b0, wa0, n0} !== {1'b0, 3'd1, 5'd1}) begin
      bad++; $display("FAIL bad_one_cycle: got b=%b wa=%0d n=%0d want 0 1 1", b0, wa0, n0);
    end
    cyc(1, 0, 0, 2'b00);
    cyc(0, 0, 1, 2'b11);
    total++;
    if (b0 !== 1'b0) begin
      bad++; $display("FAIL idle_no_bad: got %b want 0", b0);
    end
  endtask

  task automatic test_ties;
    int want[5] = '{1, 2, 3, 3, 3};
    cyc(0, 1, 0, 2'b00);
    foreach (want[i]) begin
      cyc(0, 0, 1, 2'b00);
      total++;
      if (t1 !== 2'(want[i]) || n1 !== 3'(i + 1)) begin
        bad++; $display("FAIL tie_sat%0d: got ties=%0d rounds=%0d want %0d %0d", i, t1, n1, want[i], i + 1);
      end
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 2'b00);
    total++;
    if (n1 !== 3'd7 || t0 !== 4'd9) begin
      bad++; $display("FAIL round_sat: got n1=%0d t0=%0d want 7 9", n1, t0);
    end
  endtask

  task automatic test_collision;
    cyc(0, 1, 0, 2'b00);
    cyc(0, 0, 1, 2'b10);
    cyc(0, 0, 1, 2'b10);
    total++;
    if (wb0 !== 3'd2) begin
      bad++; $display("FAIL collide_pre: got wb=%0d want 2", wb0);
    end
    cyc(0, 1, 1, 2'b10);
    total++;
    if ({wb0, r0, o0, b0, n0} !== {3'd0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      bad++; $display("FAIL collide: got wb=%0d rdy=%b over=%b bad=%b n=%0d want 0 1 0 0 0", wb0, r0, o0, b0, n0);
    end
    cyc(0, 1, 1, 2'b11);
    total++;
    if (b0 !== 1'b0) begin
      bad++; $display("FAIL collide_bad: got %b want 0", b0);
    end
  endtask

  task automatic test_reset_mid;
    cyc(0, 1, 0, 2'b00);
    cyc(0, 0, 1, 2'b01);
    cyc(0, 0, 1, 2'b01);
    cyc(1, 0, 1, 2'b01);
    total++;
    if (obs(0) !== 20'd0) begin
      bad++; $display("FAIL reset_mid: got %h want 00000", obs(0));
    end
    cyc(0, 0, 1, 2'b01);
    cyc(0, 0, 1, 2'b11);
    total++;
    if (obs(0) !== 20'd0) begin
      bad++; $display("FAIL reset_mid_idle: got %h want 00000", obs(0));
    end
    cyc(0, 1, 0, 2'b00);
    total++;
    if (r0 !== 1'b1) begin
      bad++; $display("FAIL reset_mid_restart: got %b want 1", r0);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
          ($urandom_range(3) != 0), 2'($urandom_range(3)));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++; $display("FAIL random dut%0d cyc%0d: got %h want %h", k, i, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; new_match = 1'b0; round_valid = 1'b0; score = 2'b00;
    test_reset();
    test_new_match();
    test_match();
    test_bad();
    test_ties();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rps_match_ctrl.md
# rps_match_ctrl

Match controller sitting directly downstream of the rock-paper-scissors round judge (`rps_toplevel`). It samples the judge's 2-bit round `score` on a valid strobe and keeps per-player win tallies, a tie count and a round count. It declares the match over when either player reaches `WINS_TO_MATCH` wins, holds the result, and waits for a new match request.

## Interface
- `WINS_TO_MATCH`, default 3: wins needed to take the match (best of 2N-1). Legal range is 1 to 2^`CNT_W`-1.
- `CNT_W`, default 3: width of the win counters.
- `TIE_W`, default 4: width of the tie counter.
- `RND_W`, default 5: width of the round counter.
- `clk`  in  1  single system clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high. Sampled on the `clk` rising edge.
- `new_match`  in  1  one-cycle request to clear the tallies and start a match.
- `round_valid`  in  1  one-cycle strobe: `score` is settled this cycle.
- `score`  in  2  round result from the judge. Encoding: 00 = tie, 01 = A wins, 10 = B wins, 11 = invalid play.
- `round_ready`  out  1  high while in PLAY. Strobes are accepted only when this is high.
- `wins_a`  out  `CNT_W`  rounds won by A in the current match.
- `wins_b`  out  `CNT_W`  rounds won by B in the current match.
- `ties`  out  `TIE_W`  tied rounds. Saturates at its maximum value.
- `rounds`  out  `RND_W`  accepted rounds, excluding invalid ones. Saturates at its maximum value.
- `match_over`  out  1  high in DONE.
- `winner`  out  2  01 = A, 10 = B, 00 = none yet. Never 11.
- `bad_round`  out  1  one-cycle pulse when an accepted strobe carried `score` = 11.

## Operation
- FSM states: IDLE, PLAY, DONE.
  - IDLE: if `new_match` is high, clear all counters and `winner`, then go to PLAY. `round_valid` is ignored.
  - PLAY: on `round_valid`, decode `score`:
    - 01: `wins_a` +1, `rounds` +1.
    - 10: `wins_b` +1, `rounds` +1.
    - 00: `ties` +1 (saturating), `rounds` +1.
    - 11: no counter change; pulse `bad_round`.
  - PLAY exit: if the incremented win count equals `WINS_TO_MATCH`, go to DONE in the same edge and set `winner` to the matching code.
  - DONE: hold all tallies and `winner`. `round_valid` is ignored and `bad_round` never pulses. `new_match` clears everything and goes to PLAY.
- `new_match` in PLAY restarts the match: counters are cleared and the state stays PLAY.
- Simultaneous `new_match` and `round_valid` in any state: `new_match` wins and the round is discarded. `bad_round` stays low.
- Win counters cannot overflow: the match ends at `WINS_TO_MATCH`, which is at most 2^`CNT_W`-1.

## Timing
- Every output is a registered output. No combinational path runs from the inputs to the outputs.
- Latency is one cycle. A strobe sampled at edge k is reflected in the counters, `winner`, `match_over` and `bad_round` after edge k.
- The winning strobe makes `match_over` and `winner` valid after that same edge. At that point `round_ready` is already low.
- `round_ready` is low in DONE and IDLE. The judge may keep strobing; those strobes are dropped.
- Reset values: state IDLE, every counter 0, `winner` 00, `match_over` 0, `round_ready` 0, `bad_round` 0.
- A reset asserted mid-match wins over every input in that cycle and returns the block to IDLE with all outputs at their reset values.
- Back-to-back strobes on consecutive cycles are each counted. The block has no throughput limit.

## Structure
- Shared package `rps_pkg` holds:
  - the score encoding constants: `SCORE_TIE`, `SCORE_A`, `SCORE_B`, `SCORE_BAD`;
  - the state encoding: `ST_IDLE`, `ST_PLAY`, `ST_DONE`;
  - the winner codes.
- The package is shared with the judge so the encoding is defined in one place.
- Sub-module `rps_sat_counter` (parameter `W`; inputs `clk`, `reset`, `clr`, `inc`; output `q`): a synchronous-clear saturating up-counter. `clr` has priority over `inc`. It is instantiated for `wins_a`, `wins_b`, `ties` and `rounds`.
- The FSM and score decode live in `rps_match_ctrl`.

## Test plan
- Reset then `new_match`: the next cycle shows `round_ready`=1, all counters 0 and `winner`=00.
- Defaults, strobe scores 01,10,01,00,01: the result is `wins_a`=3, `wins_b`=1, `ties`=1, `rounds`=5, `match_over`=1 and `winner`=01, all one cycle after the 5th strobe. A further 10 strobe leaves every value unchanged.
- Strobe 11 in PLAY: `bad_round` pulses for exactly one cycle and all counters are unchanged. The same strobe in DONE or IDLE gives no pulse.
- `TIE_W`=2, 5 tie strobes: `ties` reads 1,2,3,3,3 and `rounds`=5.
- `new_match` with `round_valid` and `score`=10 in the same cycle, with `wins_b`=2: the next cycle has `wins_b`=0 and the state is PLAY.
- `reset` asserted after 2 A wins while a strobe is present: the next cycle is IDLE with all outputs 0, and `round_valid` is ignored until `new_match`.
